// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard -- hazard and issue controller for the fewcore pipeline.
//
// Keeps a two-slot shadow (EX, WB) of in-flight destination registers and
// derives operand forwarding selects, load-use stalls and the two-cycle
// flush that follows a taken branch.
//
// Build option: FEWCORE_FWD_EN
//   defined   : EX/WB forwarding; only a load-use dependency stalls (1 cycle).
//   undefined : no forwarding; any EX/WB dependency stalls until the producer
//               has left WB; fwd_* are always 00.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   dec_valid           decode stage holds a real instruction
//   dec_rs1, dec_rs2    source registers of the decoding instruction
//   dec_rd              destination register (0 = no write)
//   dec_isLoad          decoding instruction is a load
//   ex_taken            execute resolved a taken branch this cycle
//   stall               hold PC and fetch/decode register
//   issue               load decoded instruction into decode->execute register
//   fwd_rs1, fwd_rs2    00 = regfile, 01 = execute result, 10 = write-stage data
//   flush               decode contents are wrong-path
//   stall_cnt           saturating count of stall cycles
module pipe_scoreboard #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec_valid,
  input  logic [4:0]             dec_rs1,
  input  logic [4:0]             dec_rs2,
  input  logic [4:0]             dec_rd,
  input  logic                   dec_isLoad,
  input  logic                   ex_taken,
  output logic                   stall,
  output logic                   issue,
  output logic [1:0]             fwd_rs1,
  output logic [1:0]             fwd_rs2,
  output logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  state_t state, state_nx;

  // Shadow slots
  logic       ex_v, ex_ld, wb_v;
  logic [4:0] ex_rd, wb_rd;

  // Source/slot matches; x0 never matches
  logic ex_m1, ex_m2, wb_m1, wb_m2;
  logic ld_use;
  logic hazard;

  assign ex_m1 = ex_v && (ex_rd != 5'd0) && (ex_rd == dec_rs1);
  assign ex_m2 = ex_v && (ex_rd != 5'd0) && (ex_rd == dec_rs2);
  assign wb_m1 = wb_v && (wb_rd != 5'd0) && (wb_rd == dec_rs1);
  assign wb_m2 = wb_v && (wb_rd != 5'd0) && (wb_rd == dec_rs2);

  assign ld_use = ex_ld && (ex_m1 || ex_m2);

  always_comb begin
    hazard   = 1'b0;
    fwd_rs1  = 2'b00;
    fwd_rs2  = 2'b00;
    flush    = ex_taken || (state == FLUSH);
    if (dec_valid) begin
`ifdef FEWCORE_FWD_EN
      hazard = ld_use;
      if (ex_m1 && !ex_ld)  fwd_rs1 = 2'b01;
      else if (wb_m1)       fwd_rs1 = 2'b10;
      if (ex_m2 && !ex_ld)  fwd_rs2 = 2'b01;
      else if (wb_m2)       fwd_rs2 = 2'b10;
`else
      // Without a bypass path every pending producer blocks the reader,
      // whether it is a load, an ALU op in EX, or anything still in WB.
      hazard = ld_use
            || (!ex_ld && (ex_m1 || ex_m2))
            || wb_m1 || wb_m2;
`endif
    end
    // A taken branch (or the flush that follows it) discards the decode
    // instruction, so a hazard on it must not stall.
    stall = hazard && !flush;
    issue = dec_valid && !stall && !flush;
  end

  always_comb begin
    state_nx = RUN;
    if (ex_taken) begin
      state_nx = FLUSH;
    end else if (state == RUN) begin
`ifdef FEWCORE_FWD_EN
      if (stall) state_nx = LOAD_STALL;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      ex_v      <= 1'b0;
      ex_rd     <= '0;
      ex_ld     <= 1'b0;
      wb_v      <= 1'b0;
      wb_rd     <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      wb_v  <= ex_v;
      wb_rd <= ex_rd;
      ex_v  <= issue;
      ex_rd <= dec_rd;
      ex_ld <= dec_isLoad;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_isLoad;
  logic        ex_taken;
  logic        stall, issue, flush;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic [15:0] stall_cnt;

  pipe_scoreboard #(.STALL_CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .dec_valid  (dec_valid),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_rd     (dec_rd),
    .dec_isLoad (dec_isLoad),
    .ex_taken   (ex_taken),
    .stall      (stall),
    .issue      (issue),
    .fwd_rs1    (fwd_rs1),
    .fwd_rs2    (fwd_rs2),
    .flush      (flush),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        chk;
    logic        st;
    logic        is;
    logic        fl;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  // Drive one cycle of inputs and queue the hand-computed response.
  task automatic cyc(input logic rst, input logic v, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd,
                     input logic ld, input logic tk, input logic chk,
                     input logic est, input logic eis, input logic efl,
                     input logic [1:0] ef1, input logic [1:0] ef2,
                     input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_rd = rd; dec_isLoad = ld; ex_taken = tk;
    vec_no++;
    e.idx = vec_no; e.chk = chk; e.st = est; e.is = eis; e.fl = efl;
    e.f1 = ef1; e.f2 = ef2; e.cnt = 16'(ecnt);
    exp_q.push_back(e);
  endtask

  task automatic cmp(input int idx, input string name, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, sample mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          cmp(e.idx, "stall",     16'(stall),   16'(e.st));
          cmp(e.idx, "issue",     16'(issue),   16'(e.is));
          cmp(e.idx, "flush",     16'(flush),   16'(e.fl));
          cmp(e.idx, "fwd_rs1",   16'(fwd_rs1), 16'(e.f1));
          cmp(e.idx, "fwd_rs2",   16'(fwd_rs2), 16'(e.f2));
          cmp(e.idx, "stall_cnt", stall_cnt,    e.cnt);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
    dec_rd = '0; dec_isLoad = 1'b0; ex_taken = 1'b0;
    //   rst v  rs1 rs2 rd ld tk chk  st is fl f1 f2 cnt
`ifdef FEWCORE_FWD_EN
    cyc(1, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    cyc(0, 1,  1,  2,  5, 0, 0, 1,   0, 1, 0, 0, 0, 0);  // add x5
    cyc(0, 1,  5,  3,  6, 0, 0, 1,   0, 1, 0, 1, 0, 0);  // sub reads x5 -> EX
    cyc(0, 1,  4,  5,  8, 0, 0, 1,   0, 1, 0, 0, 2, 0);  // reads x5 -> WB
    cyc(0, 1,  1,  0,  7, 1, 0, 1,   0, 1, 0, 0, 0, 0);  // lw x7
    cyc(0, 1,  2,  7,  9, 0, 0, 1,   1, 0, 0, 0, 0, 0);  // load-use stall
    cyc(0, 1,  2,  7,  9, 0, 0, 1,   0, 1, 0, 0, 2, 1);  // re-eval, WB fwd
    cyc(0, 1,  1,  1,  0, 0, 0, 1,   0, 1, 0, 0, 0, 1);  // writes x0
    cyc(0, 1,  0,  0, 10, 0, 0, 1,   0, 1, 0, 0, 0, 1);  // reads x0
    cyc(0, 1,  3,  0, 11, 0, 1, 1,   0, 0, 1, 0, 0, 1);  // branch taken
    cyc(0, 1,  1,  2, 11, 0, 0, 1,   0, 0, 1, 0, 0, 1);  // second flush slot
    cyc(0, 1,  1,  2, 12, 0, 0, 1,   0, 1, 0, 0, 0, 1);  // normal issue
    cyc(0, 1,  1,  0, 13, 1, 0, 1,   0, 1, 0, 0, 0, 1);  // lw x13
    cyc(0, 1, 13,  0, 14, 0, 1, 1,   0, 0, 1, 0, 0, 1);  // hazard + taken
    cyc(0, 0,  0,  0,  0, 0, 0, 1,   0, 0, 1, 0, 0, 1);  // FLUSH state
    cyc(0, 1,  1,  0, 14, 1, 0, 1,   0, 1, 0, 0, 0, 1);  // lw x14
    cyc(0, 1, 14,  0, 15, 0, 0, 1,   1, 0, 0, 0, 0, 1);  // load-use stall
    cyc(1, 1, 14,  0, 15, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // reset in LOAD_STALL
    cyc(0, 1, 14,  0, 15, 0, 0, 1,   0, 1, 0, 0, 0, 0);  // RUN, empty slots
    cyc(0, 0, 15,  0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0);  // invalid -> fwd 00
    cyc(0, 1, 15,  0,  0, 0, 0, 1,   0, 1, 0, 2, 0, 0);  // x15 in WB
`else
    cyc(1, 0,  0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    cyc(0, 1,  1,  2,  3, 0, 0, 1,   0, 1, 0, 0, 0, 0);  // add x3
    cyc(0, 1,  3,  4,  5, 0, 0, 1,   1, 0, 0, 0, 0, 0);  // x3 in EX: stall
    cyc(0, 1,  3,  4,  5, 0, 0, 1,   1, 0, 0, 0, 0, 1);  // x3 in WB: stall
    cyc(0, 1,  3,  4,  5, 0, 0, 1,   0, 1, 0, 0, 0, 2);  // issues
    cyc(0, 1,  1,  1,  0, 0, 0, 1,   0, 1, 0, 0, 0, 2);  // writes x0
    cyc(0, 1,  0,  0,  6, 0, 0, 1,   0, 1, 0, 0, 0, 2);  // reads x0
    cyc(0, 1,  1,  2,  7, 1, 0, 1,   0, 1, 0, 0, 0, 2);  // lw x7
    cyc(0, 1,  2,  7,  8, 0, 0, 1,   1, 0, 0, 0, 0, 2);  // load in EX: stall
    cyc(0, 1,  2,  7,  8, 0, 1, 1,   0, 0, 1, 0, 0, 3);  // taken beats stall
    cyc(0, 1,  1,  0,  8, 0, 0, 1,   0, 0, 1, 0, 0, 3);  // second flush slot
    cyc(0, 1,  1,  2,  9, 0, 0, 1,   0, 1, 0, 0, 0, 3);  // normal issue
    cyc(0, 1,  9,  0, 10, 0, 0, 1,   1, 0, 0, 0, 0, 3);  // x9 in EX: stall
    cyc(1, 1,  9,  0, 10, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // reset
    cyc(0, 1,  9,  0, 10, 0, 0, 1,   0, 1, 0, 0, 0, 0);  // empty slots
    cyc(0, 0, 10,  0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0);  // invalid: no stall
    cyc(0, 1, 10,  0,  0, 0, 0, 1,   1, 0, 0, 0, 0, 0);  // x10 in WB: stall
`endif
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
